// File: rtl/pck_len_rd_ctrl.sv
// -----------------------------------------------------------------------------
// pck_len_rd_ctrl
// Read-side controller for a packet-length buffer. It pops one entry at a time,
// waits one cycle for the buffer's registered read data, and presents the
// length downstream with a valid/ready handshake. Entries of zero length are
// dropped and flagged with a one-cycle pulse. A sticky flag records any time
// the writer/reader pointer distance exceeds the buffer depth.
//
// Ports
//   int_buffer_clk      in   rising-edge clock
//   int_buffer_rstn     in   asynchronous active-low reset
//   int_buffer_sw_rstn  in   synchronous active-high soft reset
//   wr_ptr_i            in   writer pointer (index + wrap bit), binary
//   rd_en_o             out  read strobe to the buffer (combinational)
//   rd_addr_o           out  read pointer (index + wrap bit)
//   buffer_empty_o      out  wr_ptr_i == read pointer (combinational)
//   rd_data_i           in   buffer read data, valid one cycle after rd_en_o
//   pck_len_o           out  packet length presented downstream
//   pck_len_valid_o     out  pck_len_o valid
//   pck_len_ready_i     in   downstream accepts pck_len_o
//   zero_len_err_o      out  one-cycle pulse: zero-length entry discarded
//   ptr_err_o           out  sticky pointer-distance error
//   fill_level_o        out  wr_ptr_i - read pointer, modulo 2**(ADDR_WIDTH+1)
// -----------------------------------------------------------------------------
module pck_len_rd_ctrl #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                  int_buffer_clk,
    input  logic                  int_buffer_rstn,
    input  logic                  int_buffer_sw_rstn,
    input  logic [ADDR_WIDTH:0]   wr_ptr_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH:0]   rd_addr_o,
    output logic                  buffer_empty_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] pck_len_o,
    output logic                  pck_len_valid_o,
    input  logic                  pck_len_ready_i,
    output logic                  zero_len_err_o,
    output logic                  ptr_err_o,
    output logic [ADDR_WIDTH:0]   fill_level_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   PTR_ZERO = '0;
    localparam logic [ADDR_WIDTH:0]   PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] LEN_ZERO = '0;

    state_t                state_r;
    logic [ADDR_WIDTH:0]   rd_ptr_r;
    logic                  empty_s;
    logic                  rd_en_s;
    logic [ADDR_WIDTH:0]   fill_s;

    // Empty detection, fill level and the read strobe; the soft reset blocks
    // the strobe so no pointer advance can coincide with it.
    always_comb begin
        empty_s = (wr_ptr_i == rd_ptr_r);
        fill_s  = wr_ptr_i - rd_ptr_r;
        rd_en_s = 1'b0;
        if ((state_r == IDLE) && !empty_s && !int_buffer_sw_rstn) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    assign rd_en_o        = rd_en_s;
    assign rd_addr_o      = rd_ptr_r;
    assign buffer_empty_o = empty_s;
    assign fill_level_o   = fill_s;

    // Read FSM, read pointer and all registered outputs.
    always_ff @(posedge int_buffer_clk or negedge int_buffer_rstn) begin
        if (!int_buffer_rstn) begin
            state_r         <= IDLE;
            rd_ptr_r        <= PTR_ZERO;
            pck_len_o       <= LEN_ZERO;
            pck_len_valid_o <= 1'b0;
            zero_len_err_o  <= 1'b0;
            ptr_err_o       <= 1'b0;
        end else if (int_buffer_sw_rstn) begin
            state_r         <= IDLE;
            rd_ptr_r        <= PTR_ZERO;
            pck_len_o       <= LEN_ZERO;
            pck_len_valid_o <= 1'b0;
            zero_len_err_o  <= 1'b0;
            ptr_err_o       <= 1'b0;
        end else begin
            // Pulse output: low unless the WAIT branch raises it this edge.
            zero_len_err_o <= 1'b0;
            // A distance above DEPTH can only come from a corrupted pointer.
            if (fill_s > DEPTH_C) begin
                ptr_err_o <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (rd_en_s) begin
                        // Natural binary overflow toggles the wrap bit.
                        rd_ptr_r <= rd_ptr_r + PTR_ONE;
                        state_r  <= WAIT;
                    end
                end
                WAIT: begin
                    pck_len_o <= rd_data_i;
                    if (rd_data_i == LEN_ZERO) begin
                        zero_len_err_o <= 1'b1;
                        state_r        <= IDLE;
                    end else begin
                        pck_len_valid_o <= 1'b1;
                        state_r         <= VALID;
                    end
                end
                VALID: begin
                    if (pck_len_valid_o && pck_len_ready_i) begin
                        pck_len_valid_o <= 1'b0;
                        state_r         <= IDLE;
                    end
                end
                default: begin
                    pck_len_valid_o <= 1'b0;
                    state_r         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pck_len_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pck_len_rd_ctrl
// Directed bench for pck_len_rd_ctrl: reset, single read, back-pressure,
// zero-length discard, pointer wrap, fill-level boundary, pointer error and
// soft reset. Inputs change #1 after the rising edge; outputs are checked
// there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_pck_len_rd_ctrl;

    logic        clk;
    logic        rst_n;
    logic        sw_rstn;
    logic [5:0]  wr_ptr;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic        empty;
    logic [11:0] rd_data;
    logic [11:0] pck_len;
    logic        valid;
    logic        ready;
    logic        zlen;
    logic        perr;
    logic [5:0]  fill;

    int errors = 0;
    int checks = 0;

    pck_len_rd_ctrl #(.DATA_WIDTH(12), .ADDR_WIDTH(5), .DEPTH(32)) dut (
        .int_buffer_clk     (clk),
        .int_buffer_rstn    (rst_n),
        .int_buffer_sw_rstn (sw_rstn),
        .wr_ptr_i           (wr_ptr),
        .rd_en_o            (rd_en),
        .rd_addr_o          (rd_addr),
        .buffer_empty_o     (empty),
        .rd_data_i          (rd_data),
        .pck_len_o          (pck_len),
        .pck_len_valid_o    (valid),
        .pck_len_ready_i    (ready),
        .zero_len_err_o     (zlen),
        .ptr_err_o          (perr),
        .fill_level_o       (fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; sw_rstn = 1'b0; wr_ptr = 6'd0; rd_data = 12'd0; ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b want 1", empty); end checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %0b want 0", rd_en); end checks++;
        if (rd_addr !== 6'd0) begin errors++; $display("FAIL rst_rd_addr: got %0d want 0", rd_addr); end checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", valid); end checks++;
        if (pck_len !== 12'd0) begin errors++; $display("FAIL rst_pck_len: got %0d want 0", pck_len); end checks++;
        if (zlen !== 1'b0) begin errors++; $display("FAIL rst_zlen: got %0b want 0", zlen); end checks++;
        if (perr !== 1'b0) begin errors++; $display("FAIL rst_perr: got %0b want 0", perr); end checks++;
        if (fill !== 6'd0) begin errors++; $display("FAIL rst_fill: got %0d want 0", fill); end checks++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read;
        wr_ptr = 6'd1; ready = 1'b1;
        #1;
        if (rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en: got %0b want 1", rd_en); end checks++;
        if (rd_addr !== 6'd0) begin errors++; $display("FAIL single_addr0: got %0d want 0", rd_addr); end checks++;
        if (fill !== 6'd1) begin errors++; $display("FAIL single_fill: got %0d want 1", fill); end checks++;
        tick();
        rd_data = 12'd64;
        #1;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL single_wait_rd_en: got %0b want 0", rd_en); end checks++;
        if (rd_addr !== 6'd1) begin errors++; $display("FAIL single_addr1: got %0d want 1", rd_addr); end checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %0b want 1", empty); end checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", valid); end checks++;
        tick();
        if (valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", valid); end checks++;
        if (pck_len !== 12'd64) begin errors++; $display("FAIL single_len: got %0d want 64", pck_len); end checks++;
        tick();
        if (valid !== 1'b0) begin errors++; $display("FAIL single_accept: got %0b want 0", valid); end checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL single_idle_rd_en: got %0b want 0", rd_en); end checks++;
    endtask

    task automatic test_backpressure;
        ready = 1'b0; wr_ptr = 6'd3;
        #1;
        if (rd_en !== 1'b1 || rd_addr !== 6'd1) begin errors++; $display("FAIL bp_issue: got rd_en=%0b addr=%0d want 1/1", rd_en, rd_addr); end checks++;
        tick();
        rd_data = 12'd100;
        tick();
        for (int i = 0; i < 5; i++) begin
            rd_data = 12'(200 + i);
            tick();
            if (valid !== 1'b1 || pck_len !== 12'd100) begin errors++; $display("FAIL bp_hold: got valid=%0b len=%0d want 1/100", valid, pck_len); end checks++;
            if (rd_en !== 1'b0) begin errors++; $display("FAIL bp_no_rd: got %0b want 0", rd_en); end checks++;
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        if (valid !== 1'b0) begin errors++; $display("FAIL bp_accept: got %0b want 0", valid); end checks++;
        if (rd_en !== 1'b1 || rd_addr !== 6'd2) begin errors++; $display("FAIL bp_next: got rd_en=%0b addr=%0d want 1/2", rd_en, rd_addr); end checks++;
    endtask

    task automatic test_zero_len;
        tick();
        rd_data = 12'd0; wr_ptr = 6'd4;
        tick();
        if (zlen !== 1'b1) begin errors++; $display("FAIL zl_pulse: got %0b want 1", zlen); end checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL zl_valid: got %0b want 0", valid); end checks++;
        if (rd_en !== 1'b1 || rd_addr !== 6'd3) begin errors++; $display("FAIL zl_next_rd: got rd_en=%0b addr=%0d want 1/3", rd_en, rd_addr); end checks++;
        tick();
        rd_data = 12'd7; ready = 1'b1;
        if (zlen !== 1'b0) begin errors++; $display("FAIL zl_single: got %0b want 0", zlen); end checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL zl_wait_valid: got %0b want 0", valid); end checks++;
        tick();
        if (valid !== 1'b1 || pck_len !== 12'd7) begin errors++; $display("FAIL zl_next_len: got valid=%0b len=%0d want 1/7", valid, pck_len); end checks++;
        tick();
    endtask

    task automatic test_wrap;
        int n;
        wr_ptr = 6'd31; ready = 1'b1; rd_data = 12'd5;
        n = 0;
        while (rd_addr !== 6'd31 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin errors++; $display("FAIL wrap_budget: got addr=%0d want 31", rd_addr); end checks++;
        tick();
        tick();
        if (rd_addr !== 6'd31 || empty !== 1'b1 || rd_en !== 1'b0) begin errors++; $display("FAIL wrap_at31: got addr=%0d empty=%0b rd_en=%0b want 31/1/0", rd_addr, empty, rd_en); end checks++;
        wr_ptr = 6'b100000;
        #1;
        if (fill !== 6'd1 || rd_en !== 1'b1) begin errors++; $display("FAIL wrap_fill: got fill=%0d rd_en=%0b want 1/1", fill, rd_en); end checks++;
        tick();
        rd_data = 12'd9;
        if (rd_addr !== 6'b100000) begin errors++; $display("FAIL wrap_ptr: got %0d want 32", rd_addr); end checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0b want 1", empty); end checks++;
        tick();
        if (pck_len !== 12'd9) begin errors++; $display("FAIL wrap_len: got %0d want 9", pck_len); end checks++;
        tick();
    endtask

    task automatic test_fill_boundary;
        wr_ptr = 6'd32;
        #1;
        if (fill !== 6'd32 || empty !== 1'b0) begin errors++; $display("FAIL fb_fill: got fill=%0d empty=%0b want 32/0", fill, empty); end checks++;
        tick();
        rd_data = 12'd1; ready = 1'b1;
        if (perr !== 1'b0) begin errors++; $display("FAIL fb_no_perr: got %0b want 0", perr); end checks++;
        tick();
        tick();
    endtask

    task automatic test_ptr_err_soft_reset;
        wr_ptr = 6'd33;
        #1;
        if (fill !== 6'd33 || rd_en !== 1'b1) begin errors++; $display("FAIL pe_fill: got fill=%0d rd_en=%0b want 33/1", fill, rd_en); end checks++;
        tick();
        rd_data = 12'd50; wr_ptr = 6'd2; ready = 1'b0;
        if (perr !== 1'b1) begin errors++; $display("FAIL pe_set: got %0b want 1", perr); end checks++;
        tick();
        if (valid !== 1'b1 || pck_len !== 12'd50) begin errors++; $display("FAIL pe_read_cont: got valid=%0b len=%0d want 1/50", valid, pck_len); end checks++;
        if (perr !== 1'b1 || fill !== 6'd1) begin errors++; $display("FAIL pe_sticky: got perr=%0b fill=%0d want 1/1", perr, fill); end checks++;
        sw_rstn = 1'b1; ready = 1'b1;
        tick();
        if (valid !== 1'b0 || pck_len !== 12'd0) begin errors++; $display("FAIL sw_outputs: got valid=%0b len=%0d want 0/0", valid, pck_len); end checks++;
        if (rd_addr !== 6'd0 || perr !== 1'b0 || zlen !== 1'b0) begin errors++; $display("FAIL sw_state: got addr=%0d perr=%0b zlen=%0b want 0/0/0", rd_addr, perr, zlen); end checks++;
        if (rd_en !== 1'b0) begin errors++; $display("FAIL sw_rd_block: got %0b want 0", rd_en); end checks++;
        tick();
        if (rd_addr !== 6'd0) begin errors++; $display("FAIL sw_no_advance: got %0d want 0", rd_addr); end checks++;
        sw_rstn = 1'b0;
        #1;
        if (rd_en !== 1'b1) begin errors++; $display("FAIL sw_release: got %0b want 1", rd_en); end checks++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_reset();
        test_fill_boundary();
        test_reset();
        test_ptr_err_soft_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pck_len_rd_ctrl.md
PCK_LEN_RD_CTRL -- requirements
Module: pck_len_rd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, packet-length entry width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, buffer index width; pointers are ADDR_WIDTH+1 bits with a wrap bit.
REQ-003 SHALL have parameter DEPTH, default 32, buffer entries; DEPTH == 2**ADDR_WIDTH.
REQ-004 SHALL use one clock and an asynchronous active-low reset: int_buffer_clk  in  1  rising-edge clock.
REQ-005 int_buffer_rstn  in  1  asynchronous active-low reset.
REQ-006 int_buffer_sw_rstn  in  1  synchronous active-high soft reset.
REQ-007 wr_ptr_i  in  ADDR_WIDTH+1  writer pointer, same clock domain, binary.
REQ-008 rd_en_o  out  1  read strobe to the length buffer.
REQ-009 rd_addr_o  out  ADDR_WIDTH+1  read pointer to the length buffer.
REQ-010 buffer_empty_o  out  1  buffer-empty flag to the length buffer.
REQ-011 rd_data_i  in  DATA_WIDTH  registered read data from the buffer, valid one cycle after rd_en_o.
REQ-012 pck_len_o  out  DATA_WIDTH  packet length presented downstream.
REQ-013 pck_len_valid_o  out  1  pck_len_o valid.
REQ-014 pck_len_ready_i  in  1  downstream accepts pck_len_o.
REQ-015 zero_len_err_o  out  1  one-cycle pulse: zero-length entry discarded.
REQ-016 ptr_err_o  out  1  sticky pointer-corruption flag.
REQ-017 fill_level_o  out  ADDR_WIDTH+1  entries held, wr_ptr_i - rd_ptr modulo 2**(ADDR_WIDTH+1).

Function
REQ-018 buffer_empty_o SHALL be combinational: 1 when wr_ptr_i == rd_ptr, all bits.
REQ-019 rd_addr_o SHALL equal the internal rd_ptr register at all times.
REQ-020 FSM states SHALL be IDLE, WAIT, VALID.
REQ-021 IDLE: rd_en_o = !buffer_empty_o (combinational); when asserted, rd_ptr increments by 1 (wrap bit toggles on index wrap) and state -> WAIT at the edge; else stay IDLE.
REQ-022 rd_en_o SHALL be 0 in WAIT and VALID.
REQ-023 WAIT: at the edge, pck_len_o <= rd_data_i; if rd_data_i == 0, zero_len_err_o pulses next cycle, valid stays 0, state -> IDLE; else pck_len_valid_o <= 1, state -> VALID.
REQ-024 VALID: pck_len_o and pck_len_valid_o SHALL hold until pck_len_valid_o && pck_len_ready_i at an edge; then pck_len_valid_o <= 0, state -> IDLE.
REQ-025 Latency SHALL be 2 cycles from rd_en_o to pck_len_valid_o; maximum throughput one entry per 3 cycles.
REQ-026 pck_len_ready_i while not valid SHALL have no effect.
REQ-027 fill_level_o SHALL be combinational subtraction, ADDR_WIDTH+1 bits, wrap-around discarded.
REQ-028 ptr_err_o SHALL set when fill_level_o > DEPTH and clear only on reset; reads continue regardless.
REQ-029 wr_ptr_i advancing in the same cycle as rd_en_o SHALL not affect the read; empty is re-evaluated next cycle.

Reset
REQ-030 On int_buffer_rstn low, asynchronously: rd_ptr = 0, state = IDLE, pck_len_o = 0, pck_len_valid_o = 0, zero_len_err_o = 0, ptr_err_o = 0.
REQ-031 int_buffer_sw_rstn high at an edge SHALL apply the same values synchronously, overriding all other activity including a pending handshake.
REQ-032 Reset mid-operation SHALL drop any in-flight or presented entry without a pulse on zero_len_err_o.
REQ-033 rd_en_o SHALL be 0 in any cycle where int_buffer_sw_rstn is high.

Verification
REQ-034 Reset, wr_ptr_i=0 -> buffer_empty_o=1, rd_en_o=0, all outputs 0, fill_level_o=0.
REQ-035 wr_ptr_i 0->1, rd_data_i=12'd64 after read, ready_i=1 -> rd_en_o at cycle 0 with rd_addr_o=0, valid and pck_len_o=64 at cycle 2, accepted, rd_ptr=1, empty=1.
REQ-036 Valid pck_len_o=100 with ready_i low for 5 cycles -> pck_len_o and valid held stable; no rd_en_o until accepted.
REQ-037 rd_data_i=0 -> zero_len_err_o single-cycle pulse, valid never asserted, next entry read.
REQ-038 rd_ptr=31, one entry -> rd_addr_o=31, then rd_ptr=6'b100000 (wrap bit set); wr_ptr_i=6'b100000 gives empty=1.
REQ-039 wr_ptr_i=33 with rd_ptr=0 -> fill_level_o=33, ptr_err_o=1 sticky; sw_rstn mid-VALID -> valid=0, rd_ptr=0, ptr_err_o=0 next cycle.
